// File: rtl/span_filler_pkg.sv
// zb_pkg: shared z-buffer span types, field widths and divider length
package zb_pkg;
  localparam int X_W = 8;
  localparam int Y_W = 8;
  localparam int Z_W = 8;
  localparam int FRAC_W = 8;
  localparam int DIV_CYCLES = 16;
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [Z_W-1:0] z;
  } point_t;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_DIV, S_READ, S_CMP, S_DONE} span_state_e;
endpackage

// File: rtl/span_filler_if.sv
// span_filler_if: span handshake plus z-buffer RAM bus; ZB_SPAN_STATS_EN adds pix_written/pix_rejected
interface span_filler_if;
  import zb_pkg::*;
  logic req_span;
  point_t point_a;
  point_t point_b;
  logic ack_span;
  logic err_row;
  logic busy;
  logic [X_W+Y_W-1:0] zb_addr;
  logic zb_rd_en;
  logic [Z_W-1:0] zb_rdata;
  logic zb_wr_en;
  logic [Z_W-1:0] zb_wdata;
`ifdef ZB_SPAN_STATS_EN
  logic [X_W:0] pix_written;
  logic [X_W:0] pix_rejected;
  modport master(output req_span, point_a, point_b, zb_rdata,
                 input ack_span, err_row, busy, zb_addr, zb_rd_en, zb_wr_en, zb_wdata, pix_written, pix_rejected);
  modport slave(input req_span, point_a, point_b, zb_rdata,
                output ack_span, err_row, busy, zb_addr, zb_rd_en, zb_wr_en, zb_wdata, pix_written, pix_rejected);
`else
  modport master(output req_span, point_a, point_b, zb_rdata,
                 input ack_span, err_row, busy, zb_addr, zb_rd_en, zb_wr_en, zb_wdata);
  modport slave(input req_span, point_a, point_b, zb_rdata,
                output ack_span, err_row, busy, zb_addr, zb_rd_en, zb_wr_en, zb_wdata);
`endif
endinterface

// File: rtl/span_filler_div.sv
// seq_div_u: multi-cycle unsigned restoring divider, one quotient bit per cycle
module seq_div_u #(
  parameter int N = 16,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic         done,
  output logic [N-1:0] quotient
);
  localparam int CW = $clog2(N + 1);
  logic [D-1:0] dvs, rem;
  logic [D:0] trial;
  logic fits;
  logic [CW-1:0] cnt;
  assign trial = {rem, quotient[N-1]};
  assign fits = trial >= {1'b0, dvs};
  // done marks the final iteration; quotient is complete from the following cycle
  assign done = cnt == CW'(1);
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      rem <= '0;
      dvs <= '0;
      quotient <= '0;
    end else if (start) begin
      cnt <= CW'(N);
      rem <= '0;
      dvs <= divisor;
      quotient <= dividend;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      rem <= fits ? D'(trial - {1'b0, dvs}) : trial[D-1:0];
      quotient <= {quotient[N-2:0], fits};
    end
endmodule

// File: rtl/span_filler.sv
// span_filler: z-buffered horizontal span fill; ZB_SPAN_STATS_EN adds per-span write/reject counters
module span_filler
  import zb_pkg::*;
(
  input logic clk,
  input logic rst,
  span_filler_if.slave sif
);
  span_state_e state, nxt;
  point_t pa, pb, lp, rp;
  logic [X_W-1:0] x, x_end, dx;
  logic [Z_W-1:0] z_end, dz_abs, z_pix;
  logic [DIV_CYCLES-1:0] z_acc, slope;
  logic neg, err, swap, row_ok, dz_neg, last, closer, div_start, div_done;
  always_comb begin
    swap = pa.x > pb.x;
    lp = swap ? pb : pa;
    rp = swap ? pa : pb;
    dx = rp.x - lp.x;
    dz_neg = rp.z < lp.z;
    dz_abs = dz_neg ? lp.z - rp.z : rp.z - lp.z;
    row_ok = pa.y == pb.y;
    last = x == x_end;
    z_pix = last ? z_end : z_acc[FRAC_W+Z_W-1:FRAC_W];
    closer = z_pix < sif.zb_rdata;
  end
  seq_div_u #(.N(DIV_CYCLES), .D(X_W)) u_div (
    .clk(clk),
    .rst(rst),
    .start(div_start),
    .dividend({dz_abs, {FRAC_W{1'b0}}}),
    .divisor(dx),
    .done(div_done),
    .quotient(slope)
  );
  always_ff @(posedge clk)
    state <= rst ? S_IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = sif.req_span ? S_SETUP : S_IDLE;
      S_SETUP: nxt = !row_ok ? S_DONE : dx == '0 ? S_READ : S_DIV;
      S_DIV:   nxt = div_done ? S_READ : S_DIV;
      S_READ:  nxt = S_CMP;
      S_CMP:   nxt = last ? S_DONE : S_READ;
      default: nxt = S_IDLE;
    endcase
  end
  always_comb begin
    sif.busy = state != S_IDLE;
    sif.zb_rd_en = state == S_READ;
    sif.zb_wr_en = state == S_CMP && closer;
    sif.ack_span = state == S_DONE;
    sif.err_row = state == S_DONE && err;
    sif.zb_addr = (state == S_READ || state == S_CMP) ? {pa.y, x} : '0;
    sif.zb_wdata = state == S_CMP ? z_pix : '0;
    div_start = state == S_SETUP && row_ok && dx != '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      pa <= '0;
      pb <= '0;
      x <= '0;
      x_end <= '0;
      z_end <= '0;
      z_acc <= '0;
      neg <= 1'b0;
      err <= 1'b0;
    end else begin
      if (state == S_IDLE && sif.req_span) begin
        pa <= sif.point_a;
        pb <= sif.point_b;
      end
      if (state == S_SETUP) begin
        x <= lp.x;
        x_end <= rp.x;
        z_end <= rp.z;
        z_acc <= {lp.z, {FRAC_W{1'b0}}};
        neg <= dz_neg;
        err <= !row_ok;
      end
      // x halts at the right endpoint so x=255 never wraps into the row start
      if (state == S_CMP && !last) begin
        x <= x + 1'b1;
        z_acc <= neg ? z_acc - slope : z_acc + slope;
      end
    end
`ifdef ZB_SPAN_STATS_EN
  logic [X_W:0] n_wr, n_rej;
  assign sif.pix_written = n_wr;
  assign sif.pix_rejected = n_rej;
  always_ff @(posedge clk)
    if (rst || state == S_SETUP) begin
      n_wr <= '0;
      n_rej <= '0;
    end else if (state == S_CMP) begin
      n_wr <= n_wr + (X_W+1)'(closer);
      n_rej <= n_rej + (X_W+1)'(!closer);
    end
`endif
endmodule

// File: doc/span_filler.md
Name: span_filler

Overview:
- Responder end of the initiator's span handshake.
- Accepts one horizontal span (two 24-bit points on the same row) and walks x from the left to the right endpoint.
- Interpolates depth per pixel and performs read-compare-write on the z-buffer memory, then acknowledges.
- Sits between the initiator (point_out_a/point_out_b, req/ack) and the z-buffer RAM.

Parameters:
- X_W, 8, x field width (point bits [23:16])
- Y_W, 8, y field width (point bits [15:8])
- Z_W, 8, depth field width (point bits [7:0])
- FRAC_W, 8, fractional bits of the depth slope accumulator

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_span  in  1  span request; sampled only in IDLE
- point_a  in  24  endpoint A {x,y,z}
- point_b  in  24  endpoint B {x,y,z}
- ack_span  out  1  one-cycle pulse when the span is finished
- err_row  out  1  one-cycle pulse with ack_span when y(A) != y(B)
- busy  out  1  high in every state except IDLE
- zb_addr  out  16  RAM address {y,x}
- zb_rd_en  out  1  RAM read strobe; data returns on the next cycle
- zb_rdata  in  8  RAM read data
- zb_wr_en  out  1  RAM write strobe
- zb_wdata  out  8  RAM write data (new depth)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). When rst=1 at a clk edge: state IDLE, all outputs 0, accumulators cleared.
- Reset mid-span aborts the span: no write strobe follows, no ack is issued.
- States: IDLE, SETUP, DIV, READ, CMP, DONE.
- IDLE: on req_span=1, latch point_a and point_b, then go to SETUP. req_span is ignored whenever busy=1; no queueing.
- SETUP (1 cycle):
  - If y differs, go to DONE with the error flag set.
  - Otherwise order endpoints so xl <= xr (swap A/B when xA > xB).
  - Compute dx = xr - xl, |dz| and sign of dz, where dz = zr - zl.
  - If dx = 0, go to READ. Otherwise start the divider and go to DIV.
- DIV: unsigned restoring division slope = (|dz| << FRAC_W) / dx. Takes 16 cycles; the 16-bit quotient is truncated. Then go to READ with z_acc = zl << FRAC_W and x = xl.
- READ: zb_rd_en=1, zb_addr={y,x}.
- CMP (next cycle, zb_rdata valid):
  - z_pix = z_acc[FRAC_W+Z_W-1:FRAC_W], except the last pixel (x = xr), which uses zr exactly.
  - If z_pix < zb_rdata (strict; smaller is closer), drive zb_wr_en=1, zb_wdata=z_pix, same address.
  - Then z_acc += slope (dz >= 0) or -= slope (dz < 0), x += 1.
  - Go to READ if x was below xr, else DONE.
- DONE: ack_span=1 for one cycle, err_row=flag, then IDLE.
- Latency from the req sampling edge to ack high:
  - dx > 0: 1 + 16 + 2(dx+1) cycles
  - dx = 0: 3 cycles
  - row error: 2 cycles
- Equal depth never writes.
- x = 255 endpoint: no wrap. The counter stops at xr.
- Back-to-back: a new request can be sampled on the cycle after ack_span.
- Address/data outputs are don't-care when their strobes are low, but the bench checks strobes only.

Optional Feature:
- Macro ZB_SPAN_STATS_EN.
- Defined:
  - Adds output pix_written [X_W:0]: count of writes in the last span, valid with ack_span and held until the next SETUP.
  - Adds output pix_rejected [X_W:0]: count of failed depth tests, same timing.
  - Both are cleared by rst.
- Undefined: ports and counters absent; the rest of the behaviour is identical.

Decomposition:
- Shared package zb_pkg holds:
  - point_t packed struct {x,y,z}
  - width localparams X_W/Y_W/Z_W/FRAC_W
  - span_state_e enum
  - the DIV_CYCLES=16 constant
- One sub-module: seq_div_u, a generic multi-cycle unsigned restoring divider.
  - Ports: start, dividend, divisor, done, quotient.
  - Reused later for edge slopes.

Test Plan:
- RAM preloaded 0xFF; A=24'h013201, B=24'h053209 -> slope 0x200:
  - writes at 0x3201..0x3205 with 1,3,5,7,9
  - ack 27 cycles after the req edge; err_row=0
- Swapped endpoints: A=24'h053209, B=24'h013201 -> identical writes and latency.
- Negative slope: A=24'h102040, B=24'h132010 -> slope 0x1000; writes 0x40,0x30,0x20,0x10 at 0x2010..0x2013.
- Depth test: first case with RAM[0x3203]=0x05 (equal) and RAM[0x3204]=0x02 (closer) -> no writes at 0x3203/0x3204; other three written.
- Row mismatch: A=24'h013201, B=24'h053301 -> no rd/wr strobes; ack_span and err_row pulse 2 cycles after req.
- Reset/edge cases:
  - rst pulsed during DIV, then a new request of the first case -> no writes before reset release; the second span completes normally.
  - req_span held high while busy -> exactly one ack.
